// File: rtl/fft16_scheduler.sv
// Sequencer for the shared radix-2 DIT butterfly: walks every stage/butterfly in
// place over a dual-port RAM, driving addresses, twiddle index and the start/done handshake.
module fft16_scheduler #(
  parameter int unsigned LOG2N   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_error,
  output logic [$clog2(LOG2N)-1:0]  o_stage,
  output logic                      o_rd_en,
  output logic [LOG2N-1:0]          o_addr_a,
  output logic [LOG2N-1:0]          o_addr_b,
  output logic [LOG2N-2:0]          o_tw_idx,
  output logic                      o_bf_start,
  input  logic                      i_bf_done,
  output logic                      o_wr_en
);

  localparam int unsigned SW = $clog2(LOG2N);
  localparam int unsigned CW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {IDLE, RD, ISSUE, WAIT, WR, DONE, ERR} state_t;

  state_t           state;
  logic [LOG2N-2:0] j;
  logic [CW-1:0]    wait_cnt;
  logic [SW-1:0]    s_next;
  logic [LOG2N-2:0] j_next;
  logic             last_bf;

  // Returns {addr_a, addr_b, tw_idx} for stage st, butterfly jj.
  function automatic logic [3*LOG2N-2:0] bf_index(input logic [SW-1:0] st,
                                                  input logic [LOG2N-2:0] jj);
    int unsigned      sh;
    logic [LOG2N-1:0] jw;
    logic [LOG2N-1:0] span;
    logic [LOG2N-1:0] mask;
    logic [LOG2N-1:0] a;
    logic [LOG2N-2:0] jm;
    logic [LOG2N-2:0] tw;
    sh   = 32'(st);
    jw   = {1'b0, jj};
    span = LOG2N'(1) << sh;
    mask = span - LOG2N'(1);
    a    = ((jw >> sh) << (sh + 1)) | (jw & mask);
    jm   = jj & mask[LOG2N-2:0];
    tw   = jm << (LOG2N - 1 - sh);
    return {a, a | span, tw};
  endfunction

  always_comb begin
    j_next  = j + (LOG2N-1)'(1);
    s_next  = (j == '1) ? o_stage + SW'(1) : o_stage;
    last_bf = (o_stage == SW'(LOG2N-1)) && (j == '1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_error    <= 1'b0;
      o_stage    <= '0;
      o_rd_en    <= 1'b0;
      o_addr_a   <= '0;
      o_addr_b   <= '0;
      o_tw_idx   <= '0;
      o_bf_start <= 1'b0;
      o_wr_en    <= 1'b0;
      j          <= '0;
      wait_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            o_stage <= '0;
            j       <= '0;
            o_error <= 1'b0;
            o_busy  <= 1'b1;
            o_rd_en <= 1'b1;
            {o_addr_a, o_addr_b, o_tw_idx} <= bf_index('0, '0);
            state   <= RD;
          end
        end
        RD: begin
          o_rd_en    <= 1'b0;
          o_bf_start <= 1'b1;
          state      <= ISSUE;
        end
        ISSUE: begin
          o_bf_start <= 1'b0;
          wait_cnt   <= '0;
          state      <= WAIT;
        end
        WAIT: begin
          if (i_bf_done) begin
            o_wr_en <= 1'b1;
            state   <= WR;
          end else if (wait_cnt == CW'(TIMEOUT-1)) begin
            o_error <= 1'b1;
            o_busy  <= 1'b0;
            state   <= ERR;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        WR: begin
          o_wr_en <= 1'b0;
          if (last_bf) begin
            o_done <= 1'b1;
            o_busy <= 1'b0;
            state  <= DONE;
          end else begin
            // Next butterfly's indices are registered on entry to RD so they are stable for its whole lifetime.
            o_stage <= s_next;
            j       <= j_next;
            o_rd_en <= 1'b1;
            {o_addr_a, o_addr_b, o_tw_idx} <= bf_index(s_next, j_next);
            state   <= RD;
          end
        end
        DONE: begin
          o_done <= 1'b0;
          state  <= IDLE;
        end
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
